copro_sequencer: RTL and testbench

COPRO_SEQUENCER -- requirements
Module: copro_sequencer

---
 rtl/copro_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_copro_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/copro_sequencer.sv
`default_nettype none

`ifndef TB_MANT_SIZE
`define TB_MANT_SIZE 23
`endif
`ifndef TB_EXP_SIZE
`define TB_EXP_SIZE 8
`endif

// +--------------------------------------------------------------------------+
// | Module   : copro_sequencer                                               |
// | Purpose  : Multicycle floating-point coprocessor sequencer. Captures two |
// |            operands and an opcode, holds the captured values for         |
// |            EXEC_CYCLES cycles while a combinational add/sub/mul settles, |
// |            then latches the result and pulses done.                      |
// | Ports    : clk, reset_n (async, active-low)                              |
// |            start, opcode[1:0], op_a, op_b       - request                |
// |            busy, done, result, err, ovr         - status / result        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// Float format: {sign, exponent[Ne-1:0], mantissa[Nm-1:0]}, bias 2^(Ne-1)-1.
// Exponent 0 is zero (no subnormals); results are truncated; exponent
// underflow flushes to zero, overflow saturates to the largest finite value.
// Status outputs are registered from the state, so they trail the state
// register by one cycle (done is high in the cycle after the DONE state).
module copro_sequencer #(
  parameter int Nm          = `TB_MANT_SIZE,
  parameter int Ne          = `TB_EXP_SIZE,
  parameter int EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [Ne+Nm:0]   op_a,
  input  logic [Ne+Nm:0]   op_b,
  output logic             busy,
  output logic             done,
  output logic [Ne+Nm:0]   result,
  output logic             err,
  output logic             ovr
);

  localparam int W    = Ne + Nm + 1;
  localparam int BIAS = (1 << (Ne - 1)) - 1;
  localparam int EMAX = (1 << Ne) - 1;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Largest finite magnitude, used when the exponent overflows.
  function automatic logic [W-1:0] f_sat(input logic sgn);
    return {sgn, {(Ne-1){1'b1}}, 1'b0, {Nm{1'b1}}};
  endfunction

  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic            sgn;
    logic [Ne-1:0]   ea, eb;
    logic [2*Nm+1:0] prod;
    logic [Nm-1:0]   mant;
    int              e;
    sgn  = a[W-1] ^ b[W-1];
    ea   = a[W-2:Nm];
    eb   = b[W-2:Nm];
    prod = {{(Nm+1){1'b0}}, 1'b1, a[Nm-1:0]} * {{(Nm+1){1'b0}}, 1'b1, b[Nm-1:0]};
    e    = int'(ea) + int'(eb) - BIAS;
    // Product of two [1,2) significands lies in [1,4): at most one renormalising shift.
    if (prod[2*Nm+1]) begin
      mant = prod[2*Nm:Nm+1];
      e    = e + 1;
    end else begin
      mant = prod[2*Nm-1:Nm];
    end
    if (ea == '0 || eb == '0 || e <= 0) return '0;
    if (e >= EMAX) return f_sat(sgn);
    return {sgn, e[Ne-1:0], mant};
  endfunction

  function automatic logic [W-1:0] f_add_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
    logic          sa, sb, sl;
    logic [Ne-1:0] el, es;
    logic [Nm+1:0] ml, ms, sum, sh;
    logic [Nm-1:0] mant;
    int            diff, e, msb;
    sa = a[W-1];
    sb = b[W-1] ^ sub;
    // Order by magnitude so the subtraction below never goes negative.
    if (a[W-2:0] >= b[W-2:0]) begin
      sl = sa; el = a[W-2:Nm]; es = b[W-2:Nm];
      ml = (el == '0) ? '0 : {2'b01, a[Nm-1:0]};
      ms = (es == '0) ? '0 : {2'b01, b[Nm-1:0]};
    end else begin
      sl = sb; el = b[W-2:Nm]; es = a[W-2:Nm];
      ml = (el == '0) ? '0 : {2'b01, b[Nm-1:0]};
      ms = (es == '0) ? '0 : {2'b01, a[Nm-1:0]};
    end
    diff = int'(el) - int'(es);
    ms   = (diff > Nm + 1) ? '0 : (ms >> diff);
    sum  = (sa == sb) ? (ml + ms) : (ml - ms);
    e    = int'(el);
    if (sum == '0) return '0;
    if (sum[Nm+1]) begin
      mant = sum[Nm:1];
      e    = e + 1;
    end else begin
      // Cancellation: bring the leading one back to the hidden-bit position.
      msb = 0;
      for (int i = 0; i <= Nm; i++) begin
        if (sum[i]) msb = i;
      end
      sh   = sum << (Nm - msb);
      mant = sh[Nm-1:0];
      e    = e - (Nm - msb);
    end
    if (e <= 0) return '0;
    if (e >= EMAX) return f_sat(sl);
    return {sl, e[Ne-1:0], mant};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]     opc_q, opc_d;
  logic [W-1:0]   result_q, result_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d, ovr_q, ovr_d;
  logic [W-1:0]   alu_res;

  // Multicycle path: settles from the captured registers during EXEC.
  always_comb begin
    alu_res = '0;
    case (opc_q)
      2'b00:   alu_res = f_add_sub(a_q, b_q, 1'b0);
      2'b01:   alu_res = f_add_sub(a_q, b_q, 1'b1);
      2'b10:   alu_res = f_mul(a_q, b_q);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    opc_d    = opc_q;
    result_d = result_q;
    busy_d   = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);
    err_d    = (state_q == S_DONE) && (opc_q == OP_ILLEGAL);
    ovr_d    = ovr_q | (start && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          opc_d   = opcode;
          cnt_d   = CNT_INIT;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (opc_q != OP_ILLEGAL) result_d = alu_res;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opc_q    <= opc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
  assign ovr    = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_copro_sequencer.sv
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : tb_copro_sequencer                                            |
// | Purpose  : Directed self-checking bench for copro_sequencer              |
// |            (Nm=23, Ne=8, EXEC_CYCLES=2).                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_copro_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, err, ovr;
  logic [31:0] result;

  int n_checks = 0;
  int n_err    = 0;

  copro_sequencer #(.Nm(23), .Ne(8), .EXEC_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .opcode  (opcode),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step over one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    op_a = a; op_b = b; opcode = op; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges from the capture edge until done is seen, bounded at 20.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Independent reference: IEEE double arithmetic on operands whose
  // significands are short enough that the single-precision product is exact.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  initial begin
    int lat;
    int dones;
    logic [31:0] a, b, exp_res;

    // ---------------- reset state ----------------
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovr", ovr, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // ---------------- add 1.0 + 2.0, cycle-exact timing ----------------
    op_a = 32'h3F800000; op_b = 32'h40000000; opcode = 2'b00; start = 1'b1;
    tick();                                   // edge 0: capture
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("add_busy_e%0d", e), busy, (e <= 3) ? 1 : 0);
      check($sformatf("add_done_e%0d", e), done, (e == 3) ? 1 : 0);
      check($sformatf("add_err_e%0d", e), err, 0);
    end
    check("add_result", result, 32'h40400000);

    // ---------------- illegal opcode after the add ----------------
    issue(32'h0, 32'h0, 2'b11);
    wait_done(lat);
    check("ill_latency", lat, 3);
    check("ill_err", err, 1);
    check("ill_result_kept", result, 32'h40400000);
    tick();
    check("ill_done_width", done, 0);
    check("ill_err_clear", err, 0);

    // ---------------- sub 3.0 - 1.0 with inputs changed after capture ----------------
    issue(32'h40400000, 32'h3F800000, 2'b01);
    op_a = 32'h0; op_b = 32'h0; opcode = 2'b00;
    wait_done(lat);
    check("sub_latency", lat, 3);
    check("sub_result", result, 32'h40000000);
    check("sub_err", err, 0);
    tick();
    check("sub_done_width", done, 0);

    // ---------------- 200 random multiplies ----------------
    for (int i = 0; i < 200; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 8'($urandom_range(0, 255)), 15'd0};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 8'($urandom_range(0, 255)), 15'd0};
      exp_res = r2f(f2r(a) * f2r(b));
      issue(a, b, 2'b10);
      wait_done(lat);
      check($sformatf("mul%0d_result a=%h b=%h", i, a, b), result, exp_res);
      tick();
      check($sformatf("mul%0d_done_width", i), done, 0);
    end

    // ---------------- start held high for 6 edges ----------------
    check("ovr_before", ovr, 0);
    op_a = 32'h3F800000; op_b = 32'h40000000; opcode = 2'b00; start = 1'b1;
    dones = 0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 5) start = 1'b0;
      if (done === 1'b1) dones++;
      check($sformatf("ovr_e%0d", e), ovr, (e >= 1) ? 1 : 0);
    end
    check("ovr_two_ops", dones, 2);
    check("ovr_result", result, 32'h40400000);
    tick();
    tick();
    check("ovr_held", ovr, 1);

    // ---------------- reset in the middle of EXEC ----------------
    issue(32'h40400000, 32'h3F800000, 2'b01);
    tick();                                   // now in EXEC
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ovr", ovr, 0);
    check("mid_rst_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    check("mid_rst_result_kept", result, 0);
    issue(32'h40400000, 32'h3F800000, 2'b01);
    wait_done(lat);
    check("post_rst_latency", lat, 3);
    check("post_rst_result", result, 32'h40000000);
    check("post_rst_ovr", ovr, 0);
    tick();
    check("post_rst_done_width", done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
